// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multiply/divide unit: latches operands, steps the
// shared iteration counter and captures the datapath result with a ready pulse.
module multdiv_ctrl #(
    parameter int unsigned MULT_CYCLES = 17,
    parameter int unsigned DIV_CYCLES  = 33
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [31:0] mult_product,
    input  logic        mult_overflow,
    input  logic [31:0] div_quotient,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic [31:0] counter,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DIVZ,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  counter_q, counter_d;
    logic [31:0] mult_a_q, mult_a_d;
    logic [31:0] mult_b_q, mult_b_d;
    logic [31:0] div_a_q, div_a_d;
    logic [31:0] div_b_q, div_b_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;

    // A start pulse overrides whatever is in flight, so it is decoded ahead of
    // the per-state behaviour; MULT has priority over DIV.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        mult_a_d  = mult_a_q;
        mult_b_d  = mult_b_q;
        div_a_d   = div_a_q;
        div_b_d   = div_b_q;
        result_d  = result_q;
        exc_d     = exc_q;

        if (ctrl_MULT) begin
            mult_a_d  = data_operandA;
            mult_b_d  = data_operandB;
            counter_d = '0;
            state_d   = S_MULT;
        end else if (ctrl_DIV) begin
            div_a_d   = data_operandA;
            div_b_d   = data_operandB;
            counter_d = '0;
            state_d   = (data_operandB == '0) ? S_DIVZ : S_DIV;
        end else begin
            case (state_q)
                S_IDLE: counter_d = '0;
                S_MULT: begin
                    if (counter_q == 6'(MULT_CYCLES)) begin
                        result_d  = mult_product;
                        exc_d     = mult_overflow;
                        counter_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        counter_d = counter_q + 6'd1;
                    end
                end
                S_DIV: begin
                    if (counter_q == 6'(DIV_CYCLES)) begin
                        result_d  = div_quotient;
                        exc_d     = 1'b0;
                        counter_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        counter_d = counter_q + 6'd1;
                    end
                end
                S_DIVZ: begin
                    result_d  = '0;
                    exc_d     = 1'b1;
                    counter_d = '0;
                    state_d   = S_DONE;
                end
                S_DONE: begin
                    counter_d = '0;
                    state_d   = S_IDLE;
                end
                default: begin
                    counter_d = '0;
                    state_d   = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            mult_a_q  <= '0;
            mult_b_q  <= '0;
            div_a_q   <= '0;
            div_b_q   <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            mult_a_q  <= mult_a_d;
            mult_b_q  <= mult_b_d;
            div_a_q   <= div_a_d;
            div_b_q   <= div_b_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
        end
    end

    assign mult_a         = mult_a_q;
    assign mult_b         = mult_b_q;
    assign div_a          = div_a_q;
    assign div_b          = div_b_q;
    assign counter        = {26'd0, counter_q};
    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == S_DONE);
    assign busy           = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_DIVZ);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: vector table of complete operations plus
// hand sequences for abort, simultaneous start and mid-operation reset.
module tb_multdiv_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] mult_product, div_quotient;
    logic        mult_overflow;
    logic [31:0] mult_a, mult_b, div_a, div_b, counter, data_result;
    logic        data_exception, data_resultRDY, busy;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [31:0] cur_prod, cur_quot;
    logic        cur_ovf;
    logic [31:0] em_a, em_b, ed_a, ed_b;

    multdiv_ctrl #(.MULT_CYCLES(17), .DIV_CYCLES(33)) dut (
        .clk(clk), .resetn(resetn), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .mult_product(mult_product), .mult_overflow(mult_overflow),
        .div_quotient(div_quotient), .mult_a(mult_a), .mult_b(mult_b),
        .div_a(div_a), .div_b(div_b), .counter(counter), .data_result(data_result),
        .data_exception(data_exception), .data_resultRDY(data_resultRDY), .busy(busy)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: the real answer is only presented on the capture cycle.
    always_comb begin
        mult_product  = (counter == 32'd17) ? cur_prod : (32'hBAD0_0000 | counter);
        mult_overflow = (counter == 32'd17) ? cur_ovf : ~cur_ovf;
        div_quotient  = (counter == 32'd33) ? cur_quot : (32'hD1D0_0000 | counter);
    end

    typedef struct {
        string       name;
        logic        is_div;
        int unsigned hold;
        logic [31:0] a, b, prod, quot;
        logic        ovf;
        int unsigned lat;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_pairs(input string tag);
        chk({tag, "_mult_a"}, mult_a, em_a);
        chk({tag, "_mult_b"}, mult_b, em_b);
        chk({tag, "_div_a"}, div_a, ed_a);
        chk({tag, "_div_b"}, div_b, ed_b);
    endtask

    task automatic run_op(input vec_t v);
        int unsigned cyc, lat;
        cur_prod = v.prod;
        cur_ovf  = v.ovf;
        cur_quot = v.quot;
        if (v.is_div) ctrl_DIV = 1'b1;
        else ctrl_MULT = 1'b1;
        data_operandA = v.a;
        data_operandB = v.b;
        repeat (v.hold + 1) tick();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        if (v.is_div) begin ed_a = v.a; ed_b = v.b; end
        else begin em_a = v.a; em_b = v.b; end
        chk_pairs(v.name);
        cyc = 1;
        lat = 0;
        while (cyc <= 60 && lat == 0) begin
            if (data_resultRDY) lat = cyc;
            else begin
                chk({v.name, "_busy"}, {31'd0, busy}, 32'd1);
                chk({v.name, "_counter"}, counter, cyc - 1);
                tick();
                cyc++;
            end
        end
        chk({v.name, "_latency"}, lat, v.lat);
        chk({v.name, "_result"}, data_result, v.res);
        chk({v.name, "_exc"}, {31'd0, data_exception}, {31'd0, v.exc});
        chk({v.name, "_done_busy"}, {31'd0, busy}, 32'd0);
        chk({v.name, "_done_counter"}, counter, 32'd0);
        tick();
        chk({v.name, "_rdy_pulse"}, {31'd0, data_resultRDY}, 32'd0);
        chk({v.name, "_idle_result"}, data_result, v.res);
    endtask

    initial begin
        int unsigned n;
        vecs[0] = '{"mul_7_m3", 1'b0, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'h0, 1'b0, 19, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{"div_100_7", 1'b1, 0, 32'd100, 32'd7, 32'h0, 32'd14, 1'b0, 35, 32'd14, 1'b0};
        vecs[2] = '{"div_by_0", 1'b1, 0, 32'd5, 32'd0, 32'h0, 32'h1234, 1'b0, 2, 32'd0, 1'b1};
        vecs[3] = '{"mul_ovf", 1'b0, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 1'b1, 19, 32'h0, 1'b1};
        vecs[4] = '{"div_max", 1'b1, 0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0, 35, 32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{"mul_held", 1'b0, 3, 32'd12, 32'd11, 32'd132, 32'h0, 1'b0, 19, 32'd132, 1'b0};

        resetn = 1'b0;
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;
        cur_prod = '0; cur_quot = '0; cur_ovf = 1'b0;
        em_a = '0; em_b = '0; ed_a = '0; ed_b = '0;
        repeat (3) tick();
        resetn = 1'b1;

        // Quiet after reset: everything stays zero.
        for (int i = 0; i < 50; i++) begin
            chk("quiet_outs", mult_a | mult_b | div_a | div_b | counter | data_result |
                {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
            tick();
        end

        foreach (vecs[i]) run_op(vecs[i]);

        // Multiply abandoned by a divide at counter 9: no RDY for the multiply.
        cur_prod = 32'hFFFF_FFEB;
        ctrl_MULT = 1'b1; data_operandA = 32'd7; data_operandB = 32'hFFFF_FFFD;
        tick();
        ctrl_MULT = 1'b0;
        em_a = 32'd7; em_b = 32'hFFFF_FFFD;
        n = 0;
        while (counter != 32'd9 && n < 30) begin
            chk("abort_no_rdy", {31'd0, data_resultRDY}, 32'd0);
            tick();
            n++;
        end
        chk("abort_reach_9", counter, 32'd9);
        run_op('{"abort_div", 1'b1, 0, 32'd100, 32'd7, 32'h0, 32'd14, 1'b0, 35, 32'd14, 1'b0});

        // Simultaneous start: MULT wins, divide operands untouched; then reset mid-run.
        ctrl_MULT = 1'b1; ctrl_DIV = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
        tick();
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        em_a = 32'd3; em_b = 32'd4;
        chk_pairs("both");
        chk("both_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (counter != 32'd5 && n < 30) begin tick(); n++; end
        chk("both_reach_5", counter, 32'd5);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_async_outs", mult_a | mult_b | div_a | div_b | counter | data_result |
            {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk("post_rst_no_rdy", {31'd0, data_resultRDY}, 32'd0);
            chk("post_rst_counter", counter, 32'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencer for the shared multiply/divide unit.
- Accepts single-cycle op requests from the pipeline and latches the operands.
- Drives the iteration counter into the radix-4 Booth multiplier datapath or the restoring divider datapath, then captures the result and exception.
- Returns the result with a one-cycle ready pulse; sits between the execute stage and the two iterative datapaths.

Parameters:
- MULT_CYCLES, 17, counter value at which the multiplier product is valid (1 load cycle + 16 radix-4 steps).
- DIV_CYCLES, 33, counter value at which the divider quotient is valid (1 load cycle + 32 steps).

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- ctrl_MULT  input  1  start multiply; single-cycle pulse.
- ctrl_DIV  input  1  start divide; single-cycle pulse.
- data_operandA  input  32  multiplicand / dividend, sampled with the start pulse.
- data_operandB  input  32  multiplier / divisor, sampled with the start pulse.
- mult_product  input  32  low product from the multiplier datapath.
- mult_overflow  input  1  overflow from the multiplier datapath.
- div_quotient  input  32  quotient from the divider datapath.
- mult_a  output  32  latched multiplicand to the multiplier.
- mult_b  output  32  latched multiplier to the multiplier.
- div_a  output  32  latched dividend to the divider.
- div_b  output  32  latched divisor to the divider.
- counter  output  32  iteration count shared by both datapaths; bits 31:6 always 0.
- data_result  output  32  captured result; held until the next completion.
- data_exception  output  1  overflow or divide-by-zero for data_result.
- data_resultRDY  output  1  one-cycle pulse marking data_result valid.
- busy  output  1  high while an op is in flight.

Behaviour:
- Reset (async, resetn low): all outputs 0, state IDLE, counter 0, latched operands 0.
- States:
  - IDLE: no op in flight.
  - MULT: iterating the multiplier.
  - DIV: iterating the divider.
  - DIVZ: divide-by-zero detected.
  - DONE: result captured, ready pulse driven.
- Launch: at the edge where ctrl_MULT or ctrl_DIV is 1, the block does the following in any state, including mid-operation:
  - latches A/B into the selected pair; the other pair is unchanged;
  - sets counter to 0;
  - enters MULT or DIV; any in-flight op is abandoned with no RDY pulse.
- Simultaneous ctrl_MULT and ctrl_DIV: MULT wins; DIV is ignored.
- Divide-by-zero: ctrl_DIV with data_operandB == 0 enters DIVZ instead of DIV. DIVZ then goes to DONE on the next edge with data_result = 0 and data_exception = 1.
- MULT: counter increments by 1 per edge.
  - Cycle with counter == MULT_CYCLES: that edge captures data_result = mult_product and data_exception = mult_overflow.
  - State goes to DONE and counter returns to 0.
- DIV: same rule at counter == DIV_CYCLES, capturing div_quotient with data_exception = 0.
- DONE: data_resultRDY = 1 for exactly this one cycle; next state IDLE.
  - A start pulse in DONE launches normally; RDY is still 1 in that DONE cycle.
- busy = 1 in MULT, DIV and DIVZ; 0 in IDLE and DONE.
- Latency, measured from the start edge to the first cycle with RDY high:
  - multiply: MULT_CYCLES + 2 cycles (19);
  - divide: DIV_CYCLES + 2 cycles (35);
  - divide-by-zero: 2 cycles.
- IDLE: counter holds 0; data_result and data_exception hold their last values.
- Start pulses held high for more than one cycle relaunch on every edge; RDY occurs only after a full, uninterrupted run.
- All registers are on clk rising edge; no combinational path from inputs to outputs except busy and RDY, which are decoded from state.

Test Plan:
- Reset release, no starts: all outputs 0 for 50 cycles, counter stays 0.
- ctrl_MULT with A=7, B=-3:
  - mult_a=7 and mult_b=0xFFFFFFFD from the next cycle;
  - counter runs 0..17;
  - data_result=0xFFFFFFEB, exception 0, RDY high exactly on cycle 19 for one cycle;
  - busy low afterwards.
- ctrl_DIV with A=100, B=7 → counter runs 0..33; data_result=14, RDY on cycle 35, exception 0.
- ctrl_DIV with A=5, B=0 → DIVZ for one cycle; RDY on cycle 2 with data_result=0, data_exception=1; counter stays 0.
- ctrl_MULT, then ctrl_DIV at counter=9 (A=100, B=7):
  - no RDY for the multiply;
  - counter restarts at 0;
  - RDY 35 cycles after the DIV pulse with result 14.
- ctrl_MULT and ctrl_DIV together, then resetn low at counter=5:
  - MULT launched; the DIV operands are unchanged;
  - during reset, all outputs are 0 asynchronously;
  - no RDY occurs after release.
